// File: rtl/intc_arbiter.sv
// Round-robin interrupt controller: grants one level request at a time to the CPU
// and turns CPU acknowledge / end-of-interrupt into per-source IACK / IEND pulses.
module intc_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned VW = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [N-1:0]  SRC_IRQ,
    output logic [N-1:0]  SRC_IACK,
    output logic [N-1:0]  SRC_IEND,
    input  logic          MASK_WE,
    input  logic [N-1:0]  MASK_DATA,
    output logic [N-1:0]  MASK,
    output logic          CPU_IRQ,
    output logic [VW-1:0] CPU_VECTOR,
    input  logic          CPU_ACK,
    input  logic          CPU_EOI,
    output logic          BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_ACK,
        S_SERVICE,
        S_END
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [VW-1:0]  ptr;
    logic [VW-1:0]  vector;
    logic [N-1:0]   mask;
    logic [N-1:0]   eligible;
    logic           found;
    logic [VW-1:0]  winner;
    logic [VW-1:0]  scan_idx;
    logic [N-1:0]   vector_onehot;

    assign eligible = SRC_IRQ & ~mask;

    // Walk the sources from ptr upwards with wrap at N; first eligible one wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
            scan_idx = (scan_idx == VW'(N - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_IDLE;
            ptr    <= '0;
            vector <= '0;
            mask   <= '1;
        end else begin
            state <= state_next;
            if (MASK_WE) begin
                mask <= MASK_DATA;
            end
            if (state == S_IDLE && found) begin
                vector <= winner;
            end
            if (state == S_END) begin
                ptr <= (vector == VW'(N - 1)) ? '0 : vector + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (found) state_next = S_PEND;
            S_PEND:    if (CPU_ACK) state_next = S_ACK;
            S_ACK:     state_next = S_SERVICE;
            S_SERVICE: if (CPU_EOI) state_next = S_END;
            S_END:     state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        vector_onehot         = '0;
        vector_onehot[vector] = 1'b1;
    end

    assign SRC_IACK   = (state == S_ACK) ? vector_onehot : '0;
    assign SRC_IEND   = (state == S_END) ? vector_onehot : '0;
    assign CPU_IRQ    = (state == S_PEND);
    assign CPU_VECTOR = vector;
    assign BUSY       = (state != S_IDLE);
    assign MASK       = mask;

endmodule

// File: tb/tb_intc_arbiter.sv
// Bench for intc_arbiter: directed protocol scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_intc_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned VW = 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [N-1:0]  SRC_IRQ;
    logic [N-1:0]  SRC_IACK;
    logic [N-1:0]  SRC_IEND;
    logic          MASK_WE;
    logic [N-1:0]  MASK_DATA;
    logic [N-1:0]  MASK;
    logic          CPU_IRQ;
    logic [VW-1:0] CPU_VECTOR;
    logic          CPU_ACK;
    logic          CPU_EOI;
    logic          BUSY;

    int total = 0;
    int bad   = 0;

    // Reference model: where the current grant stands in its lifecycle.
    // 0 = no grant, 1 = waiting for CPU ack, 2 = iack cycle, 3 = in service, 4 = iend cycle
    int           m_phase;
    int           m_vec;
    int           m_ptr;
    logic [N-1:0] m_mask;

    intc_arbiter #(.N(N), .VW(VW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SRC_IRQ    (SRC_IRQ),
        .SRC_IACK   (SRC_IACK),
        .SRC_IEND   (SRC_IEND),
        .MASK_WE    (MASK_WE),
        .MASK_DATA  (MASK_DATA),
        .MASK       (MASK),
        .CPU_IRQ    (CPU_IRQ),
        .CPU_VECTOR (CPU_VECTOR),
        .CPU_ACK    (CPU_ACK),
        .CPU_EOI    (CPU_EOI),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int arbitrate(input logic [N-1:0] elig, input int ptr);
        for (int i = 0; i < int'(N); i++) begin
            int c;
            c = (ptr + i) % int'(N);
            if (elig[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge();
        logic [N-1:0] elig;
        int w;
        if (RESET) begin
            m_phase = 0;
            m_ptr   = 0;
            m_vec   = 0;
            m_mask  = '1;
        end else begin
            elig = SRC_IRQ & ~m_mask;
            case (m_phase)
                0: begin
                    w = arbitrate(elig, m_ptr);
                    if (w >= 0) begin
                        m_vec   = w;
                        m_phase = 1;
                    end
                end
                1: if (CPU_ACK) m_phase = 2;
                2: m_phase = 3;
                3: if (CPU_EOI) m_phase = 4;
                default: begin
                    m_ptr   = (m_vec + 1) % int'(N);
                    m_phase = 0;
                end
            endcase
            if (MASK_WE) m_mask = MASK_DATA;
        end
    endtask

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check_outputs();
        check("cpu_irq",  32'(CPU_IRQ),    32'(m_phase == 1));
        check("vector",   32'(CPU_VECTOR), 32'(m_vec));
        check("iack",     32'(SRC_IACK),   32'((m_phase == 2) ? onehot(m_vec) : '0));
        check("iend",     32'(SRC_IEND),   32'((m_phase == 4) ? onehot(m_vec) : '0));
        check("busy",     32'(BUSY),       32'(m_phase != 0));
        check("mask",     32'(MASK),       32'(m_mask));
    endtask

    // Inputs are changed only between calls, i.e. at the falling edge.
    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_outputs();
    endtask

    // Called with the grant just visible in PEND; runs it to completion back in IDLE.
    task automatic serve(input int exp_vec, input string tag);
        check(tag, 32'(CPU_VECTOR), 32'(exp_vec));
        CPU_ACK = 1'b1;
        step();
        CPU_ACK = 1'b0;
        SRC_IRQ[exp_vec] = 1'b0;
        step();
        CPU_EOI = 1'b1;
        step();
        CPU_EOI = 1'b0;
        step();
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        MASK_WE   = 1'b1;
        MASK_DATA = m;
        step();
        MASK_WE   = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; SRC_IRQ = '0; MASK_WE = 1'b0; MASK_DATA = '0;
        CPU_ACK = 1'b0; CPU_EOI = 1'b0;
        m_phase = 0; m_vec = 0; m_ptr = 0; m_mask = '1;

        step();
        check("rst_mask", 32'(MASK), 32'hF);
        check("rst_busy", 32'(BUSY), 32'h0);
        RESET = 1'b0;

        // Single source
        write_mask('0);
        SRC_IRQ = 4'b0100;
        step();
        check("single_irq", 32'(CPU_IRQ), 32'h1);
        check("single_vec", 32'(CPU_VECTOR), 32'h2);
        CPU_ACK = 1'b1;
        step();
        CPU_ACK = 1'b0;
        check("single_iack", 32'(SRC_IACK), 32'h4);
        SRC_IRQ = '0;
        step();
        check("single_iack_gone", 32'(SRC_IACK), 32'h0);
        CPU_EOI = 1'b1;
        step();
        CPU_EOI = 1'b0;
        check("single_iend", 32'(SRC_IEND), 32'h4);
        step();
        check("single_idle", 32'(BUSY), 32'h0);

        // Simultaneous requests, then a probe showing the pointer moved past 2
        do_reset();
        write_mask('0);
        SRC_IRQ = 4'b0101;
        step();
        serve(0, "sim_first");
        step();
        serve(2, "sim_second");
        SRC_IRQ = 4'b1001;
        step();
        serve(3, "sim_ptr3");
        SRC_IRQ = '0;

        // Fairness between sources 0 and 1 re-requesting right after service
        do_reset();
        write_mask('0);
        for (int r = 0; r < 4; r++) begin
            SRC_IRQ = SRC_IRQ | 4'b0011;
            step();
            serve(r % 2, "fair_order");
        end
        SRC_IRQ = '0;
        step();

        // Masking
        do_reset();
        write_mask(4'b0001);
        SRC_IRQ = 4'b0001;
        step();
        step();
        check("mask_block", 32'(CPU_IRQ), 32'h0);
        write_mask('0);
        check("mask_pre", 32'(CPU_IRQ), 32'h0);
        step();
        check("mask_release", 32'(CPU_IRQ), 32'h1);
        check("mask_vec", 32'(CPU_VECTOR), 32'h0);
        write_mask('1);
        check("mask_pend", 32'(CPU_IRQ), 32'h1);
        serve(0, "mask_serve");
        write_mask('0);

        // Protocol noise
        SRC_IRQ = '0;
        CPU_ACK = 1'b1;
        step();
        check("noise_ack_idle", 32'(SRC_IACK), 32'h0);
        CPU_ACK = 1'b0;
        SRC_IRQ = 4'b0010;
        CPU_EOI = 1'b1;
        step();
        step();
        check("noise_eoi_pend", 32'(SRC_IEND), 32'h0);
        check("noise_still_pend", 32'(CPU_IRQ), 32'h1);
        CPU_ACK = 1'b1;
        step();
        check("noise_ackeoi_iend", 32'(SRC_IEND), 32'h0);
        check("noise_ackeoi_iack", 32'(SRC_IACK), 32'h2);
        CPU_ACK = 1'b0; CPU_EOI = 1'b0; SRC_IRQ = '0;
        step();
        CPU_ACK = 1'b1;
        step();
        check("noise_ack_service", 32'(SRC_IACK), 32'h0);
        check("noise_service_busy", 32'(BUSY), 32'h1);
        CPU_ACK = 1'b0; CPU_EOI = 1'b1;
        step();
        check("noise_late_iend", 32'(SRC_IEND), 32'h2);
        CPU_EOI = 1'b0;
        step();

        // Reset while in service
        SRC_IRQ = 4'b0100;
        step();
        CPU_ACK = 1'b1;
        step();
        CPU_ACK = 1'b0; SRC_IRQ = '0;
        step();
        RESET = 1'b1; CPU_EOI = 1'b1;
        step();
        check("rsvc_mask", 32'(MASK), 32'hF);
        check("rsvc_iend", 32'(SRC_IEND), 32'h0);
        check("rsvc_busy", 32'(BUSY), 32'h0);
        check("rsvc_irq",  32'(CPU_IRQ), 32'h0);
        RESET = 1'b0; CPU_EOI = 1'b0;

        // Random traffic; sources hold their request until they see IACK
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < int'(N); s++) begin
                if (m_phase == 2 && m_vec == s)
                    SRC_IRQ[s] = 1'b0;
                else if (!SRC_IRQ[s] && $urandom_range(3) == 0)
                    SRC_IRQ[s] = 1'b1;
                else if ($urandom_range(31) == 0)
                    SRC_IRQ[s] = 1'b0;
            end
            CPU_ACK   = ($urandom_range(2) == 0);
            CPU_EOI   = ($urandom_range(2) == 0);
            MASK_WE   = ($urandom_range(9) == 0);
            MASK_DATA = N'($urandom);
            RESET     = ($urandom_range(99) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
